// File: rtl/bcd_result_encoder.sv
// Multi-cycle binary-to-BCD encoder: converts a two's-complement result into
// sign + packed BCD magnitude using one double-dabble step per clock.
module bcd_result_encoder #(
    parameter int WIDTH       = 32,
    parameter int DIGITS      = 10,
    parameter int DISP_DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        FINISH = 2'b10
    } state_t;

    // Digits of 5 or more become >= 8 after +3, so the following shift carries correctly.
    function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] s);
        logic [BW-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = s[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Any nonzero digit beyond what the display can show.
    function automatic logic overflow_test(input logic [BW-1:0] s);
        return |s[BW-1:4*DISP_DIGITS];
    endfunction

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] mag_r, mag_s;
    logic [BW-1:0]    scratch_r, scratch_s;
    logic             sign_r, sign_s;
    logic             load_s;
    logic [BW+WIDTH-1:0] shifted_s;

    logic             busy_r, done_r, neg_r, ovf_r;
    logic [BW-1:0]    bcd_r;

    // Next-state and datapath for one conversion step.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        mag_s     = mag_r;
        scratch_s = scratch_r;
        sign_s    = sign_r;
        load_s    = 1'b0;
        shifted_s = {add3_digits(scratch_r), mag_r} << 1;
        case (state_r)
            IDLE: begin
                if (start) begin
                    sign_s    = bin_in[WIDTH-1];
                    mag_s     = bin_in[WIDTH-1] ? (~bin_in + WIDTH'(1)) : bin_in;
                    scratch_s = {BW{1'b0}};
                    cnt_s     = {CW{1'b0}};
                    state_s   = SHIFT;
                end else begin
                    state_s   = IDLE;
                end
            end
            SHIFT: begin
                scratch_s = shifted_s[BW+WIDTH-1:WIDTH];
                mag_s     = shifted_s[WIDTH-1:0];
                cnt_s     = cnt_r + CNT_ONE;
                if (cnt_r == LAST_STEP) begin
                    state_s = FINISH;
                end else begin
                    state_s = SHIFT;
                end
            end
            FINISH: begin
                load_s  = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Conversion state and scratch registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            mag_r     <= {WIDTH{1'b0}};
            scratch_r <= {BW{1'b0}};
            sign_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            mag_r     <= mag_s;
            scratch_r <= scratch_s;
            sign_r    <= sign_s;
        end
    end

    // Output registers; results only move on the FINISH-to-IDLE edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            neg_r  <= 1'b0;
            bcd_r  <= {BW{1'b0}};
            ovf_r  <= 1'b0;
        end else begin
            busy_r <= (state_s != IDLE);
            done_r <= load_s;
            if (load_s) begin
                bcd_r <= scratch_r;
                neg_r <= sign_r;
                ovf_r <= overflow_test(scratch_r);
            end else begin
                bcd_r <= bcd_r;
                neg_r <= neg_r;
                ovf_r <= ovf_r;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign neg  = neg_r;
    assign bcd  = bcd_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_bcd_result_encoder.sv
// Self-checking bench for bcd_result_encoder: directed and random operands
// compared against a decimal-arithmetic reference model.
module tb_bcd_result_encoder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] bin_in;
    logic        busy, done, neg, ovf;
    logic [39:0] bcd;

    int total = 0;
    int bad   = 0;

    bcd_result_encoder #(.WIDTH(32), .DIGITS(10), .DISP_DIGITS(6)) dut (
        .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .neg(neg), .bcd(bcd), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint ref_mag(input logic [31:0] v);
        longint s;
        s = longint'($signed(v));
        return (s < 0) ? -s : s;
    endfunction

    function automatic logic [39:0] ref_bcd(input logic [31:0] v);
        logic [39:0] r;
        longint m;
        m = ref_mag(v);
        r = 40'd0;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input logic [31:0] v);
        return ref_mag(v) >= 64'sd1000000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One conversion; optionally re-pulse start (with another operand) at cycle repulse_at.
    task automatic convert(input logic [31:0] v, input string tag, input int repulse_at);
        logic [39:0] pb;
        logic        pn, po;
        bit          stable_ok, busy_ok;
        int          n;
        pb = bcd; pn = neg; po = ovf;
        stable_ok = 1'b1; busy_ok = 1'b1;
        bin_in = v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        bin_in = $urandom;
        n = 0;
        while (!done && n < 60) begin
            if (bcd !== pb || neg !== pn || ovf !== po) stable_ok = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (n == repulse_at) begin
                start  = 1'b1;
                bin_in = ~v;
            end else begin
                start  = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'd33);
        check({tag, "_busy_during"}, 64'(busy_ok), 64'd1);
        check({tag, "_hold_during"}, 64'(stable_ok), 64'd1);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_bcd"}, 64'(bcd), 64'(ref_bcd(v)));
        check({tag, "_neg"}, 64'(neg), 64'(v[31]));
        check({tag, "_ovf"}, 64'(ovf), 64'(ref_ovf(v)));
        tick();
        check({tag, "_done_once"}, 64'(done), 64'd0);
    endtask

    initial begin
        int first_done, second_done, n;
        logic [39:0] b1;
        logic        n1;
        bit          saw_done;

        reset = 1'b0; start = 1'b0; bin_in = 32'd0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_neg",  64'(neg),  64'd0);
        check("rst_bcd",  64'(bcd),  64'd0);
        check("rst_ovf",  64'(ovf),  64'd0);

        convert(32'd0,              "zero",   -1);
        convert(32'd123456,         "p123456", -1);
        convert(-32'sd987654,       "n987654", -1);
        convert(32'd1000000,        "p1e6",    -1);
        convert(32'h8000_0000,      "minneg",  -1);
        convert(32'h7FFF_FFFF,      "maxpos",  -1);
        convert(32'd999999,         "p999999", -1);
        convert(32'hFFFF_FFFF,      "m1",      -1);
        convert(32'd4242,           "repulse", 10);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] r;
            r = (i % 2 == 0) ? $urandom : (32'($urandom_range(0, 2000000)) - 32'd1000000);
            convert(r, "rand", -1);
        end

        // Back-to-back: start held high, 5 then -5.
        bin_in = 32'd5;
        start  = 1'b1;
        tick();
        bin_in = -32'sd5;
        first_done = -1; second_done = -1;
        n = 0;
        b1 = 40'd0; n1 = 1'b0;
        while (second_done < 0 && n < 120) begin
            tick();
            n++;
            if (done && first_done < 0) begin
                first_done = n;
                b1 = bcd; n1 = neg;
            end else if (done) begin
                second_done = n;
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b_first_latency", 64'(first_done), 64'd33);
        check("b2b_spacing", 64'(second_done - first_done), 64'd34);
        check("b2b_first_bcd", 64'(b1), 64'(ref_bcd(32'd5)));
        check("b2b_first_neg", 64'(n1), 64'd0);
        check("b2b_second_bcd", 64'(bcd), 64'(ref_bcd(-32'sd5)));
        check("b2b_second_neg", 64'(neg), 64'd1);
        repeat (3) tick();

        // Leave nonzero outputs, then abort a conversion at shift step 10.
        convert(-32'sd987654, "pre_abort", -1);
        bin_in = 32'd77;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (10) tick();
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_neg",  64'(neg),  64'd0);
        check("abort_bcd",  64'(bcd),  64'd0);
        check("abort_ovf",  64'(ovf),  64'd0);
        repeat (2) tick();
        reset = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);

        convert(32'd31415926, "post_abort", -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_result_encoder.md
# bcd_result_encoder

Multi-cycle binary-to-BCD encoder for the calculator datapath. Accepts a two's-complement arithmetic result on a start pulse. Produces a sign flag, a packed BCD magnitude and a display-overflow flag using a shift-and-add-3 (double-dabble) sequence. It is the reverse of the keypad path's BCD-to-binary conversion and feeds the seven-segment output stage.

## Interface
- WIDTH, 32, width of the two's-complement operand.
- DIGITS, 10, number of BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH.
- DISP_DIGITS, 6, number of digits the display can show; used for the overflow flag.

- clk  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin_in  input  WIDTH  two's-complement value; sampled on the edge that accepts start.
- busy  output  1  high while a conversion is in progress (SHIFT or FINISH).
- done  output  1  one-cycle pulse; results are valid from this cycle onward.
- neg  output  1  sign of the last converted operand.
- bcd  output  4*DIGITS  packed BCD magnitude; digit 0 is in bits [3:0].
- ovf  output  1  high when any digit at index >= DISP_DIGITS is nonzero.

## Operation
- States: IDLE, SHIFT, FINISH.
- IDLE with start=1 at edge E:
  - capture sign = bin_in[WIDTH-1];
  - capture magnitude = sign ? (~bin_in + 1) : bin_in, held as a WIDTH-bit unsigned value;
  - clear the BCD scratch register and set the shift counter to 0;
  - go to SHIFT.
- Most-negative operand: -2^(WIDTH-1) yields magnitude 2^(WIDTH-1) as unsigned. For WIDTH=32 this is bcd = 2147483648 with neg=1. No saturation is applied.
- SHIFT, one step per cycle:
  - add 3 to every scratch digit >= 5;
  - shift {scratch, magnitude} left by 1;
  - increment the counter.
- After WIDTH steps, go to FINISH.
- FINISH, for one cycle:
  - copy scratch to bcd, the captured sign to neg, and the overflow test to ovf;
  - pulse done;
  - return to IDLE.
- Outputs bcd, neg and ovf are registered. They hold their value until the next FINISH and do not change during a conversion.
- start while busy=1 is ignored; no queuing.
- start held high continuously starts a new conversion each time IDLE is entered.
- Zero input gives neg=0, bcd=0 and ovf=0.
- Reset (reset=0) at any time, including mid-conversion:
  - forces IDLE and clears the counter and scratch register;
  - no done is produced for the aborted conversion.
- Reset values of all outputs are 0: busy=0, done=0, neg=0, bcd=0, ovf=0.

## Timing
- Edge E accepts start. busy is high from after edge E until edge E+WIDTH+1.
- Shift steps occur on edges E+1 through E+WIDTH.
- Edge E+WIDTH+1 (FINISH to IDLE):
  - bcd, neg and ovf update;
  - done goes high for exactly one cycle;
  - busy goes low.
- Latency from the start-accepting edge to done high is WIDTH+1 cycles (33 for WIDTH=32).
- A start asserted during the done cycle is accepted at edge E+WIDTH+2. Minimum start-to-start period is WIDTH+2 cycles.
- done is never high while busy is high.
- bin_in need not be held after the accepting edge.

## Test plan
- Reset release, then start with bin_in=0:
  - outputs read all zero before done;
  - done arrives 33 cycles after the accepting edge;
  - bcd=0, neg=0, ovf=0.
- bin_in=123456 (decimal) -> bcd digits 0000123456, neg=0, ovf=0.
- bin_in=-987654 -> bcd 0000987654, neg=1, ovf=0.
- bin_in=1000000 -> bcd 0001000000, ovf=1.
- bin_in=0x80000000 -> bcd 2147483648, neg=1, ovf=1.
- bin_in=0x7FFFFFFF -> bcd 2147483647, neg=0, ovf=1.
- Handshake and reset checks:
  - start re-pulsed mid-conversion is ignored, and done occurs once at the original time;
  - reset asserted at shift step 10 -> busy=0 and all outputs 0 asynchronously, with no done afterwards;
  - back-to-back starts, 5 then -5 with start held high, give two done pulses 34 cycles apart with the correct results.
